// File: rtl/best_clct_unpack_tmb.sv
// best_clct_unpack_tmb
//   Consumer end of the best-1-of-5 CFEB pattern sorter. Each accepted word
//   (pattern, global 1/2-strip key, ccLUT carry) is decoded into CFEB index,
//   one-hot CFEB flag, local key, sort quality and L/R bit. Words are queued
//   in a 2-entry FIFO. Words with zero quality are dropped, and CFEB indices
//   that are out of range are flagged. Saturating counters track accepted,
//   dropped and error words for VME readout.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   in_vld / in_rdy         input handshake (accept = in_vld & in_rdy)
//   best_pat/key/carry      winning pattern word from the sorter
//   out_vld / out_rdy       output handshake (transfer = out_vld & out_rdy)
//   out_cfeb .. out_err     decoded fields of the FIFO head
//   cnt_clr                 synchronous clear of all counters
//   acc_cnt/drop_cnt/err_cnt saturating event counters
module best_clct_unpack_tmb #(
  parameter int MXPATB  = 7,
  parameter int MXKEYB  = 5,
  parameter int MXKEYBX = 8,
  parameter int MXPATC  = 11,
  parameter int MXCFEB  = 5,
  parameter int MXCNTB  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [MXPATB-1:0]     best_pat,
  input  logic [MXKEYBX-1:0]    best_key,
  input  logic [MXPATC-1:0]     best_carry,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [MXKEYBX-MXKEYB-1:0] out_cfeb,
  output logic [MXCFEB-1:0]     out_cfeb_1hot,
  output logic [MXKEYB-1:0]     out_key,
  output logic [MXPATB-2:0]     out_qual,
  output logic                  out_lr,
  output logic [MXPATC-1:0]     out_carry,
  output logic                  out_err,
  input  logic                  cnt_clr,
  output logic [MXCNTB-1:0]     acc_cnt,
  output logic [MXCNTB-1:0]     drop_cnt,
  output logic [MXCNTB-1:0]     err_cnt
);

  localparam int CFB = MXKEYBX - MXKEYB;
  localparam int QB  = MXPATB - 1;
  localparam int EW  = CFB + MXCFEB + MXKEYB + QB + 1 + MXPATC + 1;
  // One extra bit so MXCFEB itself is representable for the range compare.
  localparam logic [CFB:0] CFEB_LIM = MXCFEB[CFB:0];

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [MXCNTB-1:0] sat_inc(input logic [MXCNTB-1:0] v, input logic en);
    logic [MXCNTB-1:0] r;
    if (en && (v != {MXCNTB{1'b1}})) begin
      r = v + {{(MXCNTB-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic          head_vld_q, head_vld_d;
  logic          buf_vld_q, buf_vld_d;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] buf_q, buf_d;
  logic [MXCNTB-1:0] acc_q, acc_d, drop_q, drop_d, err_q, err_d;

  logic              accept_s, push_s, pop_s, err_s;
  logic [CFB-1:0]    cfeb_s;
  logic [MXCFEB-1:0] onehot_s;
  logic [EW-1:0]     entry_s;

  // The FIFO is full only when both the head and the skid entry hold data.
  assign in_rdy   = ~(head_vld_q & buf_vld_q);
  assign accept_s = in_vld & in_rdy;
  assign push_s   = accept_s & (best_pat[MXPATB-1:1] != {QB{1'b0}});
  assign pop_s    = head_vld_q & out_rdy;
  assign cfeb_s   = best_key[MXKEYBX-1:MXKEYB];
  assign err_s    = ({1'b0, cfeb_s} >= CFEB_LIM);

  // Decode the incoming word into the FIFO entry format.
  always_comb begin
    onehot_s = {MXCFEB{1'b0}};
    for (int i = 0; i < MXCFEB; i++) begin
      onehot_s[i] = (cfeb_s == i[CFB-1:0]) & ~err_s;
    end
    entry_s = {cfeb_s, onehot_s, best_key[MXKEYB-1:0], best_pat[MXPATB-1:1],
               best_pat[0], best_carry, err_s};
  end

  // FIFO next state: head is the output register, buf is the second entry.
  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    if (pop_s) begin
      if (buf_vld_q) begin
        head_d = buf_q;
        if (push_s) begin
          buf_d = entry_s;
        end else begin
          buf_vld_d = 1'b0;
        end
      end else begin
        if (push_s) begin
          head_d = entry_s;
        end else begin
          // Head data is kept so the outputs hold their last value.
          head_vld_d = 1'b0;
        end
      end
    end else begin
      if (push_s) begin
        if (head_vld_q) begin
          buf_d     = entry_s;
          buf_vld_d = 1'b1;
        end else begin
          head_d     = entry_s;
          head_vld_d = 1'b1;
        end
      end else begin
        head_d = head_q;
      end
    end
  end

  // Counter next state; clear wins over a coincident increment.
  always_comb begin
    if (cnt_clr) begin
      acc_d  = {MXCNTB{1'b0}};
      drop_d = {MXCNTB{1'b0}};
      err_d  = {MXCNTB{1'b0}};
    end else begin
      acc_d  = sat_inc(acc_q, accept_s);
      drop_d = sat_inc(drop_q, accept_s & ~push_s);
      err_d  = sat_inc(err_q, push_s & err_s);
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= {EW{1'b0}};
      head_vld_q <= 1'b0;
      buf_q      <= {EW{1'b0}};
      buf_vld_q  <= 1'b0;
      acc_q      <= {MXCNTB{1'b0}};
      drop_q     <= {MXCNTB{1'b0}};
      err_q      <= {MXCNTB{1'b0}};
    end else begin
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      acc_q      <= acc_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  assign out_vld = head_vld_q;
  assign {out_cfeb, out_cfeb_1hot, out_key, out_qual, out_lr, out_carry, out_err} = head_q;
  assign acc_cnt  = acc_q;
  assign drop_cnt = drop_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_best_clct_unpack_tmb.sv
module tb_best_clct_unpack_tmb;

  logic        clock;
  logic        reset_n;
  logic        in_vld;
  logic        in_rdy;
  logic [6:0]  best_pat;
  logic [7:0]  best_key;
  logic [10:0] best_carry;
  logic        out_vld;
  logic        out_rdy;
  logic [2:0]  out_cfeb;
  logic [4:0]  out_cfeb_1hot;
  logic [4:0]  out_key;
  logic [5:0]  out_qual;
  logic        out_lr;
  logic [10:0] out_carry;
  logic        out_err;
  logic        cnt_clr;
  logic [15:0] acc_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  int total_cnt;
  int bad_cnt;

  best_clct_unpack_tmb dut (
    .clock(clock), .reset_n(reset_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .best_pat(best_pat), .best_key(best_key), .best_carry(best_carry),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_cfeb(out_cfeb),
    .out_cfeb_1hot(out_cfeb_1hot), .out_key(out_key), .out_qual(out_qual),
    .out_lr(out_lr), .out_carry(out_carry), .out_err(out_err),
    .cnt_clr(cnt_clr), .acc_cnt(acc_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    if (obs !== exp_v) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] p, input logic [7:0] k, input logic [10:0] c);
    in_vld     = v;
    best_pat   = p;
    best_key   = k;
    best_carry = c;
  endtask

  // Full head check against hand-decoded fields.
  task automatic chk_head(input string tag, input logic [2:0] cf, input logic [4:0] oh,
                          input logic [4:0] k, input logic [5:0] q, input logic lr,
                          input logic [10:0] c, input logic e);
    chk({tag, ".vld"},   {31'd0, out_vld}, 32'd1);
    chk({tag, ".cfeb"},  {29'd0, out_cfeb}, {29'd0, cf});
    chk({tag, ".1hot"},  {27'd0, out_cfeb_1hot}, {27'd0, oh});
    chk({tag, ".key"},   {27'd0, out_key}, {27'd0, k});
    chk({tag, ".qual"},  {26'd0, out_qual}, {26'd0, q});
    chk({tag, ".lr"},    {31'd0, out_lr}, {31'd0, lr});
    chk({tag, ".carry"}, {21'd0, out_carry}, {21'd0, c});
    chk({tag, ".err"},   {31'd0, out_err}, {31'd0, e});
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    reset_n   = 1'b0;
    out_rdy   = 1'b0;
    cnt_clr   = 1'b0;
    drive(1'b0, 7'h00, 8'h00, 11'h000);
    #23;
    chk("rst.in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("rst.out_vld", {31'd0, out_vld}, 32'd0);
    chk("rst.acc", {16'd0, acc_cnt}, 32'd0);
    chk("rst.key", {27'd0, out_key}, 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    step();
    chk("idle.in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("idle.out_vld", {31'd0, out_vld}, 32'd0);
    chk("idle.cnts", {16'd0, acc_cnt | drop_cnt | err_cnt}, 32'd0);

    // Basic decode, one-cycle latency.
    out_rdy = 1'b1;
    drive(1'b1, 7'h59, 8'h6B, 11'h2A5);
    step();
    drive(1'b0, 7'h00, 8'h00, 11'h000);
    chk_head("A", 3'd3, 5'b01000, 5'h0B, 6'h2C, 1'b1, 11'h2A5, 1'b0);
    chk("A.acc", {16'd0, acc_cnt}, 32'd1);
    step();
    chk("A.popped", {31'd0, out_vld}, 32'd0);
    chk("A.hold", {27'd0, out_key}, 32'h0B);

    // Backpressure: fill, third word refused, drain in order.
    out_rdy = 1'b0;
    drive(1'b1, 7'h0F, 8'h22, 11'h111);
    step();
    chk("B.in_rdy", {31'd0, in_rdy}, 32'd1);
    drive(1'b1, 7'h7E, 8'h85, 11'h7FF);
    step();
    chk("C.full", {31'd0, in_rdy}, 32'd0);
    drive(1'b1, 7'h33, 8'h41, 11'h055);
    step();
    chk("D.refused", {31'd0, in_rdy}, 32'd0);
    chk("D.acc", {16'd0, acc_cnt}, 32'd3);
    drive(1'b0, 7'h00, 8'h00, 11'h000);
    chk_head("Bhold", 3'd1, 5'b00010, 5'h02, 6'h07, 1'b1, 11'h111, 1'b0);
    out_rdy = 1'b1;
    step();
    chk_head("C", 3'd4, 5'b10000, 5'h05, 6'h3F, 1'b0, 11'h7FF, 1'b0);
    chk("C.in_rdy", {31'd0, in_rdy}, 32'd1);
    step();
    chk("C.empty", {31'd0, out_vld}, 32'd0);

    // Back-to-back words with out_rdy=1: push and pop in the same cycle.
    drive(1'b1, 7'h02, 8'h08, 11'h001);
    step();
    drive(1'b1, 7'h04, 8'h30, 11'h002);
    step();
    drive(1'b0, 7'h00, 8'h00, 11'h000);
    chk_head("F", 3'd1, 5'b00010, 5'h10, 6'h02, 1'b0, 11'h002, 1'b0);
    step();

    // Counter clear, then a dropped (zero-quality) word.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr.acc", {16'd0, acc_cnt}, 32'd0);
    drive(1'b1, 7'h01, 8'h6B, 11'h123);
    step();
    drive(1'b0, 7'h00, 8'h00, 11'h000);
    chk("drop.vld", {31'd0, out_vld}, 32'd0);
    chk("drop.cnt", {16'd0, drop_cnt}, 32'd1);
    chk("drop.acc", {16'd0, acc_cnt}, 32'd1);

    // Out-of-range CFEB.
    drive(1'b1, 7'h59, 8'hE4, 11'h3C3);
    step();
    drive(1'b0, 7'h00, 8'h00, 11'h000);
    chk_head("E", 3'd7, 5'b00000, 5'h04, 6'h2C, 1'b1, 11'h3C3, 1'b1);
    chk("E.err_cnt", {16'd0, err_cnt}, 32'd1);
    step();

    // Clear coincident with an accept.
    cnt_clr = 1'b1;
    drive(1'b1, 7'h01, 8'h00, 11'h000);
    step();
    cnt_clr = 1'b0;
    drive(1'b0, 7'h00, 8'h00, 11'h000);
    chk("clr_acc.acc", {16'd0, acc_cnt}, 32'd0);
    chk("clr_acc.drop", {16'd0, drop_cnt}, 32'd0);

    // Saturation: 65535 dropped accepts reach FFFF, one more holds there.
    drive(1'b1, 7'h01, 8'h00, 11'h000);
    repeat (65535) @(posedge clock);
    #1;
    chk("sat.reach", {16'd0, acc_cnt}, 32'hFFFF);
    step();
    drive(1'b0, 7'h00, 8'h00, 11'h000);
    chk("sat.acc", {16'd0, acc_cnt}, 32'hFFFF);
    chk("sat.drop", {16'd0, drop_cnt}, 32'hFFFF);

    // Asynchronous reset with two entries queued.
    out_rdy = 1'b0;
    drive(1'b1, 7'h0F, 8'h22, 11'h111);
    step();
    step();
    drive(1'b0, 7'h00, 8'h00, 11'h000);
    chk("ar.full", {31'd0, in_rdy}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("ar.out_vld", {31'd0, out_vld}, 32'd0);
    chk("ar.in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("ar.key", {27'd0, out_key}, 32'd0);
    chk("ar.acc", {16'd0, acc_cnt}, 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    step();
    chk("ar.post_vld", {31'd0, out_vld}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
